// File: rtl/date_pkg.sv
// Shared types and constants for the calendar controller: state encoding,
// field widths, limits, month lengths and BCD split helpers.
package date_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_YEAR  = 2'd1,
    SET_MONTH = 2'd2,
    SET_DAY   = 2'd3
  } state_t;

  localparam int YEAR_W  = 7;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;

  localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

  localparam logic [DAY_W-1:0] DIM_LONG     = 5'd31;
  localparam logic [DAY_W-1:0] DIM_SHORT    = 5'd30;
  localparam logic [DAY_W-1:0] DIM_FEB      = 5'd28;
  localparam logic [DAY_W-1:0] DIM_FEB_LEAP = 5'd29;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
  } date_t;

  function automatic logic [3:0] bcd_tens(input logic [YEAR_W-1:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [YEAR_W-1:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/date_ctrl_days_in_month.sv
// Combinational month length lookup. February is 29 days in years divisible
// by 4 only when DATE_LEAP_YEAR_EN is defined; otherwise always 28.
module days_in_month
  import date_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   dim
);

`ifdef DATE_LEAP_YEAR_EN
  // Only the low two bits decide leapness within 2000-2099.
  logic unused_year_bits;
  assign unused_year_bits = ^year[YEAR_W-1:2];
`else
  logic unused_year_bits;
  assign unused_year_bits = ^year;
`endif

  always_comb begin
    dim = DIM_LONG;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = DIM_SHORT;
      4'd2: begin
`ifdef DATE_LEAP_YEAR_EN
        dim = (year[1:0] == 2'b00) ? DIM_FEB_LEAP : DIM_FEB;
`else
        dim = DIM_FEB;
`endif
      end
      default: dim = DIM_LONG;
    endcase
  end

endmodule

// File: rtl/date_ctrl.sv
// Day/month/year sequencer with button-driven field editing, blink divider and
// BCD split of the displayed field. Leap Februaries need DATE_LEAP_YEAR_EN.
module date_ctrl
  import date_pkg::*;
#(
  parameter int START_YEAR = 0,
  parameter int BLINK_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic [1:0]         sel,
  output logic               blink,
  output logic [3:0]         disp_hi,
  output logic [3:0]         disp_lo
);

  localparam logic [YEAR_W-1:0] YEAR_RST = YEAR_W'(START_YEAR);

  state_t               state, state_n;
  date_t                cur;
  logic [YEAR_W-1:0]    year_n;
  logic [MONTH_W-1:0]   month_n;
  logic [DAY_W-1:0]     day_raw, day_n;
  logic [DAY_W-1:0]     dim_cur, dim_nxt;
  logic [BLINK_W-1:0]   div_q;
  logic [YEAR_W-1:0]    disp_val;

  // dim_cur drives the day rollover; dim_nxt clamps the day against the
  // month/year being written on this same edge.
  days_in_month u_dim_cur (.month(cur.month), .year(cur.year), .dim(dim_cur));
  days_in_month u_dim_nxt (.month(month_n),   .year(year_n),   .dim(dim_nxt));

  always_comb begin
    state_n = state;
    year_n  = cur.year;
    month_n = cur.month;
    day_raw = cur.day;
    case (state)
      RUN: begin
        if (btn_mode) state_n = SET_YEAR;
        if (tick) begin
          if (cur.day < dim_cur) begin
            day_raw = cur.day + DAY_W'(1);
          end else begin
            day_raw = DAY_W'(1);
            if (cur.month == MONTH_MAX) begin
              month_n = MONTH_W'(1);
              year_n  = (cur.year == YEAR_MAX) ? '0 : cur.year + YEAR_W'(1);
            end else begin
              month_n = cur.month + MONTH_W'(1);
            end
          end
        end
      end
      SET_YEAR: begin
        if (btn_mode) state_n = SET_MONTH;
        else if (btn_inc)
          year_n = (cur.year == YEAR_MAX) ? '0 : cur.year + YEAR_W'(1);
      end
      SET_MONTH: begin
        if (btn_mode) state_n = SET_DAY;
        else if (btn_inc)
          month_n = (cur.month == MONTH_MAX) ? MONTH_W'(1) : cur.month + MONTH_W'(1);
      end
      SET_DAY: begin
        if (btn_mode) state_n = RUN;
        else if (btn_inc)
          day_raw = (cur.day >= dim_cur) ? DAY_W'(1) : cur.day + DAY_W'(1);
      end
      default: state_n = RUN;
    endcase
  end

  // Unconditional min() is equivalent to clamping only on month/year change,
  // since the day never exceeds the current month's length otherwise.
  assign day_n = (day_raw > dim_nxt) ? dim_nxt : day_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cur   <= '{year: YEAR_RST, month: MONTH_W'(1), day: DAY_W'(1)};
      div_q <= '0;
    end else begin
      state <= state_n;
      cur   <= '{year: year_n, month: month_n, day: day_n};
      div_q <= div_q + BLINK_W'(1);
    end
  end

  always_comb begin
    disp_val = cur.year;
    case (state)
      SET_MONTH: disp_val = YEAR_W'(cur.month);
      SET_DAY:   disp_val = YEAR_W'(cur.day);
      default:   disp_val = cur.year;
    endcase
  end

  assign year    = cur.year;
  assign month   = cur.month;
  assign day     = cur.day;
  assign sel     = state;
  assign blink   = (state != RUN) & div_q[BLINK_W-1];
  assign disp_hi = bcd_tens(disp_val);
  assign disp_lo = bcd_ones(disp_val);

endmodule

// File: tb/tb_date_ctrl.sv
// Directed bench for date_ctrl: rollover, leap, set mode, clamp, simultaneous
// events and asynchronous reset, with hand-computed expectations.
module tb_date_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic [1:0] sel;
  logic       blink;
  logic [3:0] disp_hi, disp_lo;

  int n_cmp = 0;
  int n_bad = 0;

  date_ctrl #(.START_YEAR(24), .BLINK_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .year(year), .month(month), .day(day), .sel(sel), .blink(blink),
    .disp_hi(disp_hi), .disp_lo(disp_lo)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic t, input logic m, input logic i);
    @(negedge clk); tick = t; btn_mode = m; btn_inc = i;
    @(negedge clk); tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reset, then walk the set-mode buttons to y/m/d and return to RUN.
  task automatic goto(input int y, input int m, input int d);
    do_reset();
    pulse(0, 1, 0);
    repeat ((y + 100 - 24) % 100) pulse(0, 0, 1);
    pulse(0, 1, 0);
    repeat (m - 1) pulse(0, 0, 1);
    pulse(0, 1, 0);
    repeat (d - 1) pulse(0, 0, 1);
    pulse(0, 1, 0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({year, month, day} !== {7'd24, 4'd1, 5'd1}) begin
      n_bad++; $display("FAIL reset_date got %0d/%0d/%0d want 24/1/1", year, month, day);
    end
    n_cmp++;
    if ({sel, blink, disp_hi, disp_lo} !== {2'd0, 1'b0, 4'd2, 4'd4}) begin
      n_bad++; $display("FAIL reset_ctl got sel=%0d blink=%0b disp=%0d%0d want 0 0 24", sel, blink, disp_hi, disp_lo);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_tick();
    pulse(1, 0, 0);
    n_cmp++;
    if ({year, month, day, disp_hi, disp_lo} !== {7'd24, 4'd1, 5'd2, 4'd2, 4'd4}) begin
      n_bad++; $display("FAIL tick_basic got %0d/%0d/%0d disp=%0d%0d want 24/1/2 disp=24", year, month, day, disp_hi, disp_lo);
    end
  endtask

  task automatic test_year_wrap();
    goto(99, 12, 31);
    n_cmp++;
    if ({year, month, day} !== {7'd99, 4'd12, 5'd31}) begin
      n_bad++; $display("FAIL wrap_setup got %0d/%0d/%0d want 99/12/31", year, month, day);
    end
    pulse(1, 0, 0);
    n_cmp++;
    if ({year, month, day, disp_hi, disp_lo} !== {7'd0, 4'd1, 5'd1, 4'd0, 4'd0}) begin
      n_bad++; $display("FAIL wrap_tick got %0d/%0d/%0d disp=%0d%0d want 0/1/1 disp=00", year, month, day, disp_hi, disp_lo);
    end
    pulse(1, 0, 0);
    n_cmp++;
    if ({year, month, day} !== {7'd0, 4'd1, 5'd2}) begin
      n_bad++; $display("FAIL wrap_next got %0d/%0d/%0d want 0/1/2", year, month, day);
    end
  endtask

  task automatic test_leap();
    logic [15:0] exp;
    goto(24, 2, 28);
    pulse(1, 0, 0);
`ifdef DATE_LEAP_YEAR_EN
    exp = {7'd24, 4'd2, 5'd29};
`else
    exp = {7'd24, 4'd3, 5'd1};
`endif
    n_cmp++;
    if ({year, month, day} !== exp) begin
      n_bad++; $display("FAIL leap_24 got %0d/%0d/%0d want %0d/%0d/%0d", year, month, day, exp[15:9], exp[8:5], exp[4:0]);
    end
    goto(23, 2, 28);
    pulse(1, 0, 0);
    n_cmp++;
    if ({year, month, day} !== {7'd23, 4'd3, 5'd1}) begin
      n_bad++; $display("FAIL leap_23 got %0d/%0d/%0d want 23/3/1", year, month, day);
    end
  endtask

  task automatic test_set_mode();
    int run_ones;
    logic seen0, seen1;
    do_reset();
    run_ones = 0;
    repeat (20) begin
      @(negedge clk);
      if (blink !== 1'b0) run_ones++;
    end
    n_cmp++;
    if (run_ones !== 0) begin
      n_bad++; $display("FAIL blink_run got %0d high samples want 0", run_ones);
    end
    pulse(0, 1, 0);
    n_cmp++;
    if (sel !== 2'd1) begin
      n_bad++; $display("FAIL set_sel got %0d want 1", sel);
    end
    seen0 = 1'b0; seen1 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (blink === 1'b0) seen0 = 1'b1;
      if (blink === 1'b1) seen1 = 1'b1;
    end
    n_cmp++;
    if ({seen0, seen1} !== 2'b11) begin
      n_bad++; $display("FAIL blink_set got seen0=%0b seen1=%0b want 1 1", seen0, seen1);
    end
    goto(99, 5, 10);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    n_cmp++;
    if ({year, month, day} !== {7'd0, 4'd5, 5'd10}) begin
      n_bad++; $display("FAIL set_year_wrap got %0d/%0d/%0d want 0/5/10", year, month, day);
    end
    pulse(1, 0, 0);
    n_cmp++;
    if ({sel, year, month, day} !== {2'd1, 7'd0, 4'd5, 5'd10}) begin
      n_bad++; $display("FAIL set_tick_frozen got sel=%0d %0d/%0d/%0d want 1 0/5/10", sel, year, month, day);
    end
  endtask

  task automatic test_clamp();
    logic [4:0] feb;
`ifdef DATE_LEAP_YEAR_EN
    feb = 5'd29;
`else
    feb = 5'd28;
`endif
    goto(24, 1, 31);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    n_cmp++;
    if ({sel, month, day, disp_hi, disp_lo} !== {2'd2, 4'd2, feb, 4'd0, 4'd2}) begin
      n_bad++; $display("FAIL clamp_feb got sel=%0d %0d/%0d disp=%0d%0d want 2 2/%0d disp=02", sel, month, day, disp_hi, disp_lo, feb);
    end
    pulse(0, 0, 1);
    n_cmp++;
    if ({month, day} !== {4'd3, feb}) begin
      n_bad++; $display("FAIL clamp_mar got %0d/%0d want 3/%0d", month, day, feb);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(0, 1, 0);
    pulse(0, 1, 1);
    n_cmp++;
    if ({sel, year} !== {2'd2, 7'd24}) begin
      n_bad++; $display("FAIL mode_inc got sel=%0d year=%0d want 2 24", sel, year);
    end
    do_reset();
    pulse(1, 1, 0);
    n_cmp++;
    if ({sel, day} !== {2'd1, 5'd2}) begin
      n_bad++; $display("FAIL tick_mode got sel=%0d day=%0d want 1 2", sel, day);
    end
  endtask

  task automatic test_rst_mid();
    goto(50, 7, 4);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    n_cmp++;
    if ({sel, disp_hi, disp_lo} !== {2'd3, 4'd0, 4'd5}) begin
      n_bad++; $display("FAIL setday_disp got sel=%0d disp=%0d%0d want 3 05", sel, disp_hi, disp_lo);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({sel, year, month, day, blink, disp_hi, disp_lo} !==
        {2'd0, 7'd24, 4'd1, 5'd1, 1'b0, 4'd2, 4'd4}) begin
      n_bad++; $display("FAIL rst_async got sel=%0d %0d/%0d/%0d blink=%0b disp=%0d%0d want 0 24/1/1 0 24",
                        sel, year, month, day, blink, disp_hi, disp_lo);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_year_wrap();
    test_leap();
    test_set_mode();
    test_clamp();
    test_simultaneous();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/date_ctrl.md
# date_ctrl

Calendar controller that sequences the day/month/year counters of the lab clock-display datapath. It advances the date on a day tick and carries day→month→year with correct month lengths. It also provides a button-driven set mode that edits one field at a time. Outputs feed the seven-segment digit mux as binary fields plus a BCD pair for the currently selected field.

## Interface
- START_YEAR, 0, reset value of year (0..99, two-digit year 20xx)
- BLINK_W, 24, width of free-running blink divider; blink period 2^BLINK_W clk cycles

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  single-cycle day-advance pulse, synchronous to clk
- btn_mode  in  1  single-cycle pulse (debounced upstream); cycles edit mode
- btn_inc  in  1  single-cycle pulse (debounced upstream); increments selected field
- year  out  7  0..99
- month  out  4  1..12
- day  out  5  1..31
- sel  out  2  0=RUN, 1=SET_YEAR, 2=SET_MONTH, 3=SET_DAY (state encoding)
- blink  out  1  blink enable for the selected field's digits; 0 in RUN
- disp_hi  out  4  tens digit of displayed field (year in RUN, selected field otherwise)
- disp_lo  out  4  ones digit of displayed field

## Operation
- Reset values: state RUN, year=START_YEAR, month=1, day=1, blink=0, blink divider=0; disp_hi/disp_lo = START_YEAR/10, START_YEAR%10.
- FSM: RUN -btn_mode-> SET_YEAR -btn_mode-> SET_MONTH -btn_mode-> SET_DAY -btn_mode-> RUN. No other transitions.
- RUN, tick:
  - day<dim(month,year): day+1.
  - Otherwise day=1 and month carries. Month 12 wraps to 1 with a year carry. Year 99 wraps to 0.
- RUN: btn_inc ignored.
- SET_*: tick ignored (date frozen). btn_inc increments the selected field with wrap and no carry:
  - year 99→0
  - month 12→1
  - day dim→1
- Clamp: whenever month or year changes (in set or run), next day = min(day, dim(new month, new year)) on the same edge.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February per Configuration.
- Simultaneous btn_mode and btn_inc: mode transition taken, inc discarded.
- Simultaneous tick and btn_mode in RUN: tick applied and state moves to SET_YEAR on the same edge.
- blink: MSB of the divider while state≠RUN. The divider runs in all states; blink is forced to 0 in RUN.
- Arithmetic: all fields unsigned binary. disp digits are field/10 and field%10, each 0..9.

## Timing
- All state and field registers update on posedge clk. Response to tick or button is visible 1 cycle after the pulse edge.
- sel, disp_hi, disp_lo and blink are combinational from registers: zero extra latency.
- Pulses wider than one cycle are treated as one event per high cycle. Upstream guarantees single-cycle pulses.
- Asserting rst mid-operation immediately forces reset values; the set-mode edit in progress is lost. Operation resumes on the first clk edge after deassertion.

## Configuration
- DATE_LEAP_YEAR_EN defined: February has 29 days when year%4==0, else 28. The 2000–2099 range needs no century rule.
- DATE_LEAP_YEAR_EN undefined: February always has 28 days; year does not affect dim.

## Structure
- Package date_pkg holds:
  - state encodings (RUN/SET_YEAR/SET_MONTH/SET_DAY)
  - field widths (7/4/5)
  - limits YEAR_MAX=99, MONTH_MAX=12
  - month-length constants
- Sub-module days_in_month: combinational, inputs month and year, output dim (5 bits). Leap logic is under DATE_LEAP_YEAR_EN.
- date_ctrl holds the FSM, field registers, clamp logic, blink divider and BCD split.

## Test plan
- Reset with START_YEAR=24, then one tick -> year=24, month=1, day=2; disp_hi=2, disp_lo=4.
- Date 99/12/31, tick -> 0/1/1; no stale carry on the next tick.
- Leap year, month=2, day=28, tick:
  - year=24, macro on -> day=29.
  - year=24, macro off -> 3/1.
  - year=23 -> 3/1.
- Set mode: btn_mode -> sel=1, blink toggles. btn_inc at year=99 -> 0, month unchanged. tick during SET leaves the date unchanged.
- Clamp: 1/31 in SET_MONTH, btn_inc -> month=2, day=28 (29 if leap and macro on). Next btn_inc -> month=3, day stays 28.
- Simultaneous events and reset:
  - btn_mode and btn_inc in SET_YEAR -> sel=2, year unchanged.
  - tick and btn_mode in RUN -> day+1 and sel=1.
  - rst low mid-SET_DAY -> all reset values at once.
